garage_door_ctrl: RTL and testbench
===================================

# garage_door_ctrl

Parametrised garage-door motor controller: the next generation of the two-limit up/down door FSM. It adds activate edge detection, stop/reverse on a second press, obstruction reversal while closing, an auto-close timer, a travel-timeout fault and a limit-switch consistency fault. It sits between the push-button/sensor conditioning logic and the motor driver, and drives `up_m`/`dn_m` directly.

## Interface
- `TRAVEL_MAX`, 1000: maximum cycles allowed in OPENING/CLOSING before FAULT; must be ≥1.
- `AUTO_CLOSE`, 5000: cycles the door dwells in OPEN before closing automatically; 0 disables auto-close.
- `CNT_W`, 16: counter width; `TRAVEL_MAX` and `AUTO_CLOSE` must be < 2^CNT_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `activate` in 1: push-button level, already synchronised.
- `up_max` in 1: door fully-open limit switch.
- `dn_max` in 1: door fully-closed limit switch.
- `obstruct` in 1: beam-break sensor; 1 means blocked.
- `up_m` out 1: open-motor drive.
- `dn_m` out 1: close-motor drive.
- `fault` out 1: 1 while in FAULT.
- `state_o` out 3: current state code.

## Operation
- State codes: IDLE=0, CLOSED=1, OPENING=2, OPEN=3, CLOSING=4, STOPPED=5, FAULT=6. Codes 7 and above are unreachable and recover to IDLE.
- Outputs are decoded from the state register only:
  - `up_m`=1 only in OPENING.
  - `dn_m`=1 only in CLOSING.
  - `fault`=1 only in FAULT.
  - `up_m` and `dn_m` are never 1 together.
- Press edge: `act_d` registers `activate`; `press = activate & ~act_d`.
- `last_dir` register (1=up): set when entering OPENING, cleared when entering CLOSING.
- One counter `cnt[CNT_W-1:0]`: cleared on every state change. It increments in OPENING, CLOSING and OPEN, and holds 0 elsewhere.
- Global rule: `up_max & dn_max` in any state other than FAULT sends the next state to FAULT. This has top priority.
- IDLE:
  - `dn_max` → CLOSED.
  - `up_max` → OPEN.
  - neither → STOPPED with `last_dir`=1, so the next press closes.
- CLOSED: press → OPENING.
- OPENING (priority high→low):
  - `up_max` → OPEN.
  - press → STOPPED.
  - `cnt == TRAVEL_MAX-1` → FAULT.
- CLOSING (priority high→low):
  - `dn_max` → CLOSED.
  - `obstruct` → OPENING.
  - press → STOPPED.
  - `cnt == TRAVEL_MAX-1` → FAULT.
- OPEN:
  - `obstruct` clears `cnt`.
  - press with `!obstruct` → CLOSING.
  - `AUTO_CLOSE!=0 && cnt == AUTO_CLOSE-1 && !obstruct` → CLOSING.
  - A press while `obstruct`=1 is ignored.
- STOPPED: press → CLOSING if `last_dir`=1 and `!obstruct`, otherwise OPENING. A press that would close while `obstruct`=1 is ignored.
- FAULT: sticky; both motors off; exited only by reset.

## Timing
- Reset values: state=IDLE, `act_d`=1, `last_dir`=0, `cnt`=0, `up_m`=`dn_m`=`fault`=0, `state_o`=0.
  - `act_d` resets to 1 so that a button held through reset does not produce a press.
- IDLE lasts exactly one cycle after reset deassertion.
- Press latency: `activate` first sampled high at edge N → new state and motor outputs visible after edge N.
  - A held button produces exactly one press.
  - A new press needs `activate` low for at least one sampled edge first.
- Limit, obstruction and timeout reactions also take effect at the sampling edge, with zero extra cycles.
- Travel timeout: if OPENING/CLOSING is entered at edge E and no exit occurs, FAULT is entered at edge E+TRAVEL_MAX.
- Auto-close: OPEN entered at edge E with `obstruct` continuously low → CLOSING entered at edge E+AUTO_CLOSE.
- Obstruction reversal restarts the travel timeout, because `cnt` is cleared on the state change.
- Reset asserted mid-travel: motors drop asynchronously, and the controller re-resolves position through IDLE.

## Test plan
- Reset with `dn_max`=1, pulse `activate` 1 cycle → CLOSED, then OPENING one edge after the press, `up_m`=1. Assert `up_max` → OPEN, `up_m`=0.
- `AUTO_CLOSE`=8, door OPEN, `obstruct` pulsed at cycle 5 → CLOSING occurs 8 edges after the pulse edge, not before. During CLOSING assert `obstruct` → OPENING at that edge, `dn_m`=0, `up_m`=1.
- During OPENING, press → STOPPED (both motors 0). Press again → CLOSING. Press in STOPPED with `obstruct`=1 after a prior OPENING → ignored.
- `TRAVEL_MAX`=10, press from CLOSED, never assert `up_max` → FAULT after exactly 10 edges, `fault`=1, `state_o`=6. Further presses are ignored until `rst`=0.
- `up_max`=`dn_max`=1 while CLOSING → FAULT at that edge, `dn_m`=0. Also in the same cycle as a press: FAULT wins.
- Hold `activate`=1 through and after reset with `dn_max`=1 → stays CLOSED. Assert `rst` mid-CLOSING → `dn_m` drops without waiting for a clock edge.

Source files
------------

// File: rtl/garage_door_ctrl.sv
// Garage-door motor controller: limit-switch FSM with press edge detection,
// stop/reverse, obstruction reversal, auto-close, travel timeout and limit fault.
module garage_door_ctrl #(
  parameter int TRAVEL_MAX = 1000,
  parameter int AUTO_CLOSE = 5000,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       activate,
  input  logic       up_max,
  input  logic       dn_max,
  input  logic       obstruct,
  output logic       up_m,
  output logic       dn_m,
  output logic       fault,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLOSED  = 3'd1,
    OPENING = 3'd2,
    OPEN    = 3'd3,
    CLOSING = 3'd4,
    STOPPED = 3'd5,
    FAULT   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
  localparam logic [CNT_W-1:0] AUTO_LAST   = CNT_W'((AUTO_CLOSE == 0) ? 0 : AUTO_CLOSE - 1);
  localparam logic             AUTO_EN     = (AUTO_CLOSE != 0);

  state_t           state_r, state_s;
  logic             act_d_r;
  logic             last_dir_r, last_dir_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             press_s;
  logic             up_m_r, dn_m_r, fault_r;
  logic [2:0]       state_o_r;

  assign press_s = activate & ~act_d_r;

  // Next-state, direction memory and dwell/travel counter.
  always_comb begin
    state_s    = state_r;
    last_dir_s = last_dir_r;
    cnt_s      = '0;
    case (state_r)
      IDLE: begin
        if (dn_max) begin
          state_s = CLOSED;
        end else if (up_max) begin
          state_s = OPEN;
        end else begin
          state_s    = STOPPED;
          last_dir_s = 1'b1;
        end
      end
      CLOSED: begin
        if (press_s) state_s = OPENING;
        else         state_s = CLOSED;
      end
      OPENING: begin
        if (up_max)                    state_s = OPEN;
        else if (press_s)              state_s = STOPPED;
        else if (cnt_r == TRAVEL_LAST) state_s = FAULT;
        else                           state_s = OPENING;
      end
      CLOSING: begin
        if (dn_max)                    state_s = CLOSED;
        else if (obstruct)             state_s = OPENING;
        else if (press_s)              state_s = STOPPED;
        else if (cnt_r == TRAVEL_LAST) state_s = FAULT;
        else                           state_s = CLOSING;
      end
      OPEN: begin
        if (!obstruct && (press_s || (AUTO_EN && cnt_r == AUTO_LAST))) state_s = CLOSING;
        else                                                          state_s = OPEN;
      end
      STOPPED: begin
        if (press_s && !last_dir_r)             state_s = OPENING;
        else if (press_s && !obstruct)          state_s = CLOSING;
        else                                    state_s = STOPPED;
      end
      FAULT:   state_s = FAULT;
      default: state_s = IDLE;
    endcase

    // Both limits active at once means a broken switch; overrides everything.
    if (up_max && dn_max && state_r != FAULT) state_s = FAULT;
    else                                      state_s = state_s;

    if (state_s == OPENING && state_r != OPENING)      last_dir_s = 1'b1;
    else if (state_s == CLOSING && state_r != CLOSING) last_dir_s = 1'b0;
    else                                               last_dir_s = last_dir_s;

    if (state_s != state_r)                                cnt_s = '0;
    else if (state_r == OPENING || state_r == CLOSING)     cnt_s = cnt_r + CNT_W'(1);
    else if (state_r == OPEN)                              cnt_s = obstruct ? '0 : cnt_r + CNT_W'(1);
    else                                                   cnt_s = '0;
  end

  // State, press-edge, counter and registered output decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      act_d_r    <= 1'b1;
      last_dir_r <= 1'b0;
      cnt_r      <= '0;
      up_m_r     <= 1'b0;
      dn_m_r     <= 1'b0;
      fault_r    <= 1'b0;
      state_o_r  <= 3'd0;
    end else begin
      state_r    <= state_s;
      act_d_r    <= activate;
      last_dir_r <= last_dir_s;
      cnt_r      <= cnt_s;
      up_m_r     <= (state_s == OPENING);
      dn_m_r     <= (state_s == CLOSING);
      fault_r    <= (state_s == FAULT);
      state_o_r  <= state_s;
    end
  end

  assign up_m    = up_m_r;
  assign dn_m    = dn_m_r;
  assign fault   = fault_r;
  assign state_o = state_o_r;

endmodule

// File: tb/tb_garage_door_ctrl.sv
// Directed scoreboard bench for garage_door_ctrl with TRAVEL_MAX=10, AUTO_CLOSE=8.
module tb_garage_door_ctrl;

  logic       clk = 1'b0;
  logic       rst, activate, up_max, dn_max, obstruct;
  logic       up_m, dn_m, fault;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  garage_door_ctrl #(.TRAVEL_MAX(10), .AUTO_CLOSE(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .activate(activate), .up_max(up_max), .dn_max(dn_max),
    .obstruct(obstruct), .up_m(up_m), .dn_m(dn_m), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check_now(input string tag);
    logic [2:0] e;
    logic [5:0] expv, obsv;
    e    = exp_q.pop_front();
    expv = {e, (e == 3'd2), (e == 3'd4), (e == 3'd6)};
    obsv = {state_o, up_m, dn_m, fault};
    n_tests++;
    assert (obsv === expv) else begin
      n_fail++;
      $error("FAIL %s observed {state,up,dn,fault}=%b expected=%b", tag, obsv, expv);
    end
  endtask

  task automatic expect_now(input logic [2:0] e, input string tag);
    exp_q.push_back(e);
    check_now(tag);
  endtask

  task automatic step(input logic [2:0] e, input string tag);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  initial begin
    rst = 1'b0; activate = 1'b0; up_max = 1'b0; dn_max = 1'b1; obstruct = 1'b0;
    #12;
    expect_now(3'd0, "reset_state");
    rst = 1'b1;
    step(3'd1, "idle_to_closed");
    step(3'd1, "closed_hold");
    activate = 1'b1;             step(3'd2, "press_open");
    dn_max = 1'b0;               step(3'd2, "held_no_repress");
    activate = 1'b0; up_max = 1'b1; step(3'd3, "up_limit_open");
    for (int i = 0; i < 4; i++) step(3'd3, "open_dwell");
    obstruct = 1'b1;             step(3'd3, "obstruct_in_open");
    obstruct = 1'b0;
    for (int i = 0; i < 7; i++) step(3'd3, "auto_close_restarted");
    step(3'd4, "auto_close_fires");
    up_max = 1'b0;               step(3'd4, "closing");
    obstruct = 1'b1;             step(3'd2, "obstruct_reverse");
    obstruct = 1'b0; activate = 1'b1; step(3'd5, "press_stop_opening");
    activate = 1'b0;             step(3'd5, "stopped_hold");
    activate = 1'b1;             step(3'd4, "stopped_press_close");
    activate = 1'b0;             step(3'd4, "closing_again");
    obstruct = 1'b1;             step(3'd2, "obstruct_reverse2");
    obstruct = 1'b0; activate = 1'b1; step(3'd5, "stop_again");
    activate = 1'b0; obstruct = 1'b1; step(3'd5, "stopped_obstructed");
    activate = 1'b1;             step(3'd5, "close_press_ignored");
    activate = 1'b0; obstruct = 1'b0; step(3'd5, "stopped_clear");
    activate = 1'b1;             step(3'd4, "stopped_close_clear");
    activate = 1'b0;             step(3'd4, "closing_hold");
    activate = 1'b1;             step(3'd5, "press_stop_closing");
    activate = 1'b0; obstruct = 1'b1; step(3'd5, "stopped_after_close");
    activate = 1'b1;             step(3'd2, "stopped_reopen");
    activate = 1'b0; obstruct = 1'b0;
    for (int i = 0; i < 9; i++) step(3'd2, "travel_before_timeout");
    step(3'd6, "travel_timeout");
    activate = 1'b1;             step(3'd6, "fault_press1");
    activate = 1'b0;             step(3'd6, "fault_release");
    activate = 1'b1;             step(3'd6, "fault_sticky");

    rst = 1'b0; dn_max = 1'b1; #1;
    expect_now(3'd0, "reset_clears_fault");
    #4 rst = 1'b1;
    step(3'd1, "held_through_reset");
    step(3'd1, "held_no_press");
    activate = 1'b0;             step(3'd1, "release");
    activate = 1'b1;             step(3'd2, "press_after_release");
    activate = 1'b0; dn_max = 1'b0; up_max = 1'b1; step(3'd3, "open_again");
    up_max = 1'b0; activate = 1'b1; step(3'd4, "open_press_close");
    activate = 1'b0;             step(3'd4, "closing3");
    up_max = 1'b1; dn_max = 1'b1; step(3'd6, "both_limits_closing");

    rst = 1'b0; dn_max = 1'b0; #1;
    expect_now(3'd0, "reset2");
    #4 rst = 1'b1;
    step(3'd3, "idle_to_open");
    activate = 1'b1;             step(3'd4, "press_close4");
    activate = 1'b0;             step(3'd4, "closing4");
    activate = 1'b1; dn_max = 1'b1; step(3'd6, "both_limits_beat_press");
    activate = 1'b0; dn_max = 1'b0;

    rst = 1'b0; #1;
    expect_now(3'd0, "reset3");
    #4 rst = 1'b1;
    step(3'd3, "idle_to_open2");
    activate = 1'b1;             step(3'd4, "press_close5");
    activate = 1'b0;             step(3'd4, "closing5");
    #2 rst = 1'b0; #1;
    expect_now(3'd0, "reset_mid_closing_async");
    up_max = 1'b0; dn_max = 1'b0;
    #3 rst = 1'b1;
    step(3'd5, "idle_unknown_stopped");
    activate = 1'b1;             step(3'd4, "idle_stop_then_close");
    activate = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
